updi_instr_engine: RTL and testbench
====================================

UPDI_INSTR_ENGINE -- requirements
Module: updi_instr_engine

Interface
REQ-001 Parameter TIMEOUT_CLK, default 100000: max clk cycles spent waiting for any single RX byte.
REQ-002 clk  input  1  single clock domain for all logic.
REQ-003 rst  input  1  reset, synchronous and active-high.
REQ-004 cmd_valid  input  1  command request.
REQ-005 cmd_ready  output  1  engine idle and accepting a command.
REQ-006 cmd_op  input  2  command: 0=LDCS, 1=STCS, 2=BREAK, 3=reserved.
REQ-007 cmd_addr  input  4  UPDI control/status register address.
REQ-008 cmd_data  input  8  STCS write data.
REQ-009 rsp_valid  output  1  result available.
REQ-010 rsp_ready  input  1  result consumed.
REQ-011 rsp_data  output  8  LDCS read byte; 0x00 for other ops.
REQ-012 rsp_err  output  2  0=ok, 1=echo mismatch, 2=timeout, 3=rx_error or reserved op.
REQ-013 tx_fifo_data  output  8  byte pushed to the PHY TX FIFO.
REQ-014 tx_fifo_wr_en  output  1  push strobe.
REQ-015 tx_fifo_full  input  1  PHY TX FIFO full.
REQ-016 rx_fifo_data  input  8  PHY RX FIFO head, valid whenever rx_fifo_empty=0 (first-word-fall-through).
REQ-017 rx_fifo_rd_en  output  1  pop strobe.
REQ-018 rx_fifo_empty  input  1  PHY RX FIFO empty.
REQ-019 rx_error  input  1  PHY parity/frame error flag.
REQ-020 double_break_start  output  1  one-cycle double-break request.
REQ-021 double_break_done  input  1  double break complete.

Function
REQ-022 States: IDLE, BREAK_WAIT, DRAIN, TX, ECHO, RESP, DONE.
REQ-023 cmd_ready=1 only in IDLE; a command is accepted on cmd_valid & cmd_ready, with op/addr/data registered in that cycle.
REQ-024 LDCS byte sequence: 0x55, 0x80|addr; echoes expected: 2; response bytes: 1.
REQ-025 STCS byte sequence: 0x55, 0xC0|addr, data; echoes expected: 3; response bytes: 0.
REQ-026 TX: push one byte per cycle while tx_fifo_full=0; tx_fifo_wr_en never asserted while tx_fifo_full=1; the byte index holds while full.
REQ-027 ECHO entered after the last push; each cycle with rx_fifo_empty=0 pops one byte (rx_fifo_rd_en=1) and compares it with the matching sent byte.
REQ-028 Echo mismatch -> DONE with rsp_err=1; no further pops.
REQ-029 RESP (LDCS only): pop one byte into rsp_data, then DONE with rsp_err=0.
REQ-030 Timeout counter clears on entry to ECHO/RESP and on every pop; reaching TIMEOUT_CLK-1 with FIFO still empty -> DONE with rsp_err=2.
REQ-031 rx_error=1 in any ECHO/RESP cycle -> DONE with rsp_err=3; this takes priority over a mismatch and a pop in the same cycle.
REQ-032 BREAK: pulse double_break_start for exactly one cycle, then wait in BREAK_WAIT for double_break_done (no timeout).
REQ-033 BREAK: then DRAIN pops while rx_fifo_empty=0, ignoring rx_error, and goes to DONE (rsp_err=0) on the first cycle rx_fifo_empty=1.
REQ-034 Reserved op -> DONE with rsp_err=3 on the cycle after acceptance; no FIFO activity.
REQ-035 DONE: rsp_valid=1 with rsp_data/rsp_err stable until rsp_valid & rsp_ready, then IDLE the next cycle.
REQ-036 DONE: a new command is not accepted in the handshake cycle.
REQ-037 On error, stray echo bytes left in the RX FIFO are not drained; recovery is a BREAK command.

Reset
REQ-038 rst=1 -> state IDLE, counters 0.
REQ-039 rst=1 -> cmd_ready=1 and all other outputs 0, effective next clk edge; this aborts any in-flight operation, including a pending double break wait.

Verification
REQ-040 LDCS addr=0x0: echo 0x55,0x80 then 0x30 -> TX 0x55,0x80; rsp_valid, rsp_data=0x30, rsp_err=0.
REQ-041 STCS addr=0x3, data=0x59 with tx_fifo_full held for 5 cycles mid-sequence -> pushes 0x55,0xC3,0x59 with no push while full; echoes match -> rsp_err=0, rsp_data=0x00.
REQ-042 LDCS whose second echo returns 0x81 -> rsp_err=1; rx_fifo_rd_en asserted exactly twice.
REQ-043 LDCS with no response byte, TIMEOUT_CLK=50 -> rsp_err=2 exactly 50 cycles after the last echo pop.
REQ-044 BREAK with 3 garbage bytes queued after double_break_done -> one start pulse, 3 pops, rsp_err=0; rsp_ready held low 4 cycles -> rsp_valid stays high.
REQ-045 rst asserted mid-STCS echo phase -> next cycle cmd_ready=1, all other outputs 0; the following LDCS completes normally.

Source files
------------

// File: rtl/updi_instr_engine.sv
// UPDI instruction engine: runs LDCS/STCS/BREAK command sequences over a PHY byte FIFO pair,
// checks the single-wire echo of every sent byte and returns one response per command.
module updi_instr_engine #(
  parameter int TIMEOUT_CLK = 100000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [1:0] cmd_op,
  input  logic [3:0] cmd_addr,
  input  logic [7:0] cmd_data,
  output logic       rsp_valid,
  input  logic       rsp_ready,
  output logic [7:0] rsp_data,
  output logic [1:0] rsp_err,
  output logic [7:0] tx_fifo_data,
  output logic       tx_fifo_wr_en,
  input  logic       tx_fifo_full,
  input  logic [7:0] rx_fifo_data,
  output logic       rx_fifo_rd_en,
  input  logic       rx_fifo_empty,
  input  logic       rx_error,
  output logic       double_break_start,
  input  logic       double_break_done
);

  localparam int CNT_W = $clog2(TIMEOUT_CLK + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_BREAK_WAIT,
    S_DRAIN,
    S_TX,
    S_ECHO,
    S_RESP,
    S_DONE
  } state_t;

  typedef enum logic [1:0] {
    OP_LDCS  = 2'd0,
    OP_STCS  = 2'd1,
    OP_BREAK = 2'd2,
    OP_RSVD  = 2'd3
  } op_t;

  localparam logic [1:0] ERR_OK      = 2'd0;
  localparam logic [1:0] ERR_ECHO    = 2'd1;
  localparam logic [1:0] ERR_TIMEOUT = 2'd2;
  localparam logic [1:0] ERR_RX      = 2'd3;

  state_t           state;
  op_t              op_q;
  logic [3:0]       addr_q;
  logic [7:0]       data_q;
  logic [1:0]       idx;
  logic [CNT_W-1:0] cnt;

  logic [7:0] sent_byte;
  logic [1:0] last_idx;
  logic       timeout_hit;

  // The same byte table drives the TX FIFO and is the reference for the echo compare.
  // NOTE: every variable assigned in always_comb gets a value on every path; a missing
  // default here would infer a latch.
  always_comb begin
    sent_byte = 8'h55;
    case (idx)
      2'd0:    sent_byte = 8'h55;
      2'd1:    sent_byte = (op_q == OP_LDCS) ? {4'h8, addr_q} : {4'hC, addr_q};
      default: sent_byte = data_q;
    endcase
  end

  assign last_idx    = (op_q == OP_LDCS) ? 2'd1 : 2'd2;
  assign timeout_hit = rx_fifo_empty && (cnt == CNT_W'(TIMEOUT_CLK - 1));

  // FIFO strobes must react to full/empty in the same cycle, so they are decoded from state.
  assign cmd_ready     = (state == S_IDLE);
  assign tx_fifo_data  = (state == S_TX) ? sent_byte : 8'h00;
  assign tx_fifo_wr_en = (state == S_TX) && !tx_fifo_full;
  assign rx_fifo_rd_en = (((state == S_ECHO) || (state == S_RESP)) && !rx_fifo_empty && !rx_error)
                       || ((state == S_DRAIN) && !rx_fifo_empty);

  // NOTE: sequential state uses non-blocking assignments only, so every register in this
  // block samples the pre-edge values of the others.
  always_ff @(posedge clk) begin
    if (rst) begin
      state              <= S_IDLE;
      op_q               <= OP_LDCS;
      addr_q             <= 4'h0;
      data_q             <= 8'h00;
      idx                <= 2'd0;
      cnt                <= '0;
      rsp_valid          <= 1'b0;
      rsp_data           <= 8'h00;
      rsp_err            <= ERR_OK;
      double_break_start <= 1'b0;
    end else begin
      double_break_start <= 1'b0;
      case (state)
        S_IDLE: begin
          if (cmd_valid) begin
            op_q     <= op_t'(cmd_op);
            addr_q   <= cmd_addr;
            data_q   <= cmd_data;
            idx      <= 2'd0;
            cnt      <= '0;
            rsp_data <= 8'h00;
            rsp_err  <= ERR_OK;
            case (op_t'(cmd_op))
              OP_LDCS, OP_STCS: state <= S_TX;
              OP_BREAK: begin
                double_break_start <= 1'b1;
                state              <= S_BREAK_WAIT;
              end
              default: begin
                rsp_err   <= ERR_RX;
                rsp_valid <= 1'b1;
                state     <= S_DONE;
              end
            endcase
          end
        end

        // The PHY owns the break timing, so there is no timeout on this wait.
        S_BREAK_WAIT: begin
          if (double_break_done) state <= S_DRAIN;
        end

        // Line garbage after a break is discarded regardless of rx_error.
        S_DRAIN: begin
          if (rx_fifo_empty) begin
            rsp_err   <= ERR_OK;
            rsp_valid <= 1'b1;
            state     <= S_DONE;
          end
        end

        S_TX: begin
          if (!tx_fifo_full) begin
            if (idx == last_idx) begin
              idx   <= 2'd0;
              cnt   <= '0;
              state <= S_ECHO;
            end else begin
              idx <= idx + 2'd1;
            end
          end
        end

        S_ECHO: begin
          if (rx_error) begin
            rsp_err   <= ERR_RX;
            rsp_valid <= 1'b1;
            state     <= S_DONE;
          end else if (!rx_fifo_empty) begin
            cnt <= '0;
            if (rx_fifo_data != sent_byte) begin
              rsp_err   <= ERR_ECHO;
              rsp_valid <= 1'b1;
              state     <= S_DONE;
            end else if (idx == last_idx) begin
              if (op_q == OP_LDCS) begin
                state <= S_RESP;
              end else begin
                rsp_err   <= ERR_OK;
                rsp_valid <= 1'b1;
                state     <= S_DONE;
              end
            end else begin
              idx <= idx + 2'd1;
            end
          end else if (timeout_hit) begin
            rsp_err   <= ERR_TIMEOUT;
            rsp_valid <= 1'b1;
            state     <= S_DONE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        S_RESP: begin
          if (rx_error) begin
            rsp_err   <= ERR_RX;
            rsp_valid <= 1'b1;
            state     <= S_DONE;
          end else if (!rx_fifo_empty) begin
            cnt       <= '0;
            rsp_data  <= rx_fifo_data;
            rsp_err   <= ERR_OK;
            rsp_valid <= 1'b1;
            state     <= S_DONE;
          end else if (timeout_hit) begin
            rsp_err   <= ERR_TIMEOUT;
            rsp_valid <= 1'b1;
            state     <= S_DONE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        // Response held stable; IDLE (and cmd_ready) only follows the handshake edge.
        S_DONE: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            rsp_data  <= 8'h00;
            rsp_err   <= ERR_OK;
            state     <= S_IDLE;
          end
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_updi_instr_engine.sv
// Directed bench for updi_instr_engine: FIFO models around the DUT, hand-computed expectations
// for LDCS/STCS/BREAK/reserved commands, echo errors, timeout and mid-operation reset.
module tb_updi_instr_engine;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       cmd_valid = 1'b0;
  logic       cmd_ready;
  logic [1:0] cmd_op = 2'd0;
  logic [3:0] cmd_addr = 4'h0;
  logic [7:0] cmd_data = 8'h00;
  logic       rsp_valid;
  logic       rsp_ready = 1'b0;
  logic [7:0] rsp_data;
  logic [1:0] rsp_err;
  logic [7:0] tx_fifo_data;
  logic       tx_fifo_wr_en;
  logic       tx_fifo_full = 1'b0;
  logic [7:0] rx_fifo_data = 8'h00;
  logic       rx_fifo_rd_en;
  logic       rx_fifo_empty = 1'b1;
  logic       rx_error = 1'b0;
  logic       double_break_start;
  logic       double_break_done = 1'b0;

  logic [7:0] rxq[$];
  logic [7:0] txq[$];
  logic [7:0] junk;
  int cyc = 0;
  int pops = 0;
  int wr_viol = 0;
  int starts = 0;
  int last_pop_cyc = 0;
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  updi_instr_engine #(.TIMEOUT_CLK(50)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_addr(cmd_addr), .cmd_data(cmd_data),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_err(rsp_err),
    .tx_fifo_data(tx_fifo_data), .tx_fifo_wr_en(tx_fifo_wr_en), .tx_fifo_full(tx_fifo_full),
    .rx_fifo_data(rx_fifo_data), .rx_fifo_rd_en(rx_fifo_rd_en), .rx_fifo_empty(rx_fifo_empty),
    .rx_error(rx_error),
    .double_break_start(double_break_start), .double_break_done(double_break_done)
  );

  // TX sink and first-word-fall-through RX source; bytes pushed by the stimulus appear one edge later.
  always @(posedge clk) begin
    cyc++;
    if (rx_fifo_rd_en && rxq.size() > 0) begin
      junk = rxq.pop_front();
      pops++;
      last_pop_cyc = cyc;
    end
    if (tx_fifo_wr_en) begin
      txq.push_back(tx_fifo_data);
      if (tx_fifo_full) wr_viol++;
    end
    if (double_break_start) starts++;
    rx_fifo_empty <= (rxq.size() == 0);
    rx_fifo_data  <= (rxq.size() > 0) ? rxq[0] : 8'h00;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic send_cmd(input logic [1:0] op, input logic [3:0] addr, input logic [7:0] data);
    @(negedge clk);
    chk("cmd_ready_before_cmd", {31'd0, cmd_ready}, 32'd1);
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_addr  = addr;
    cmd_data  = data;
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  task automatic wait_rsp(input int budget);
    int n = 0;
    while (!rsp_valid && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk("rsp_valid_within_budget", {31'd0, rsp_valid}, 32'd1);
  endtask

  task automatic rsp_accept();
    rsp_ready = 1'b1;
    chk("no_accept_in_handshake", {31'd0, cmd_ready}, 32'd0);
    @(negedge clk);
    rsp_ready = 1'b0;
    chk("idle_after_handshake", {31'd0, cmd_ready}, 32'd1);
    chk("rsp_valid_cleared", {31'd0, rsp_valid}, 32'd0);
  endtask

  task automatic start_test();
    txq.delete();
    pops    = 0;
    wr_viol = 0;
    starts  = 0;
  endtask

  task automatic chk_quiet(input string tag);
    chk({tag, "_cmd_ready"}, {31'd0, cmd_ready}, 32'd1);
    chk({tag, "_rsp_valid"}, {31'd0, rsp_valid}, 32'd0);
    chk({tag, "_rsp_data"}, {24'd0, rsp_data}, 32'h00);
    chk({tag, "_rsp_err"}, {30'd0, rsp_err}, 32'd0);
    chk({tag, "_tx_wr_en"}, {31'd0, tx_fifo_wr_en}, 32'd0);
    chk({tag, "_tx_data"}, {24'd0, tx_fifo_data}, 32'h00);
    chk({tag, "_rx_rd_en"}, {31'd0, rx_fifo_rd_en}, 32'd0);
    chk({tag, "_dbl_break"}, {31'd0, double_break_start}, 32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(negedge clk);
    chk_quiet("reset");
    rst = 1'b0;

    // LDCS addr 0: echoes 55,80 then read byte 30.
    start_test();
    rxq.push_back(8'h55); rxq.push_back(8'h80); rxq.push_back(8'h30);
    send_cmd(2'd0, 4'h0, 8'h00);
    wait_rsp(100);
    chk("ldcs_tx_count", txq.size(), 32'd2);
    chk("ldcs_tx0", {24'd0, txq[0]}, 32'h55);
    chk("ldcs_tx1", {24'd0, txq[1]}, 32'h80);
    chk("ldcs_pops", pops, 32'd3);
    chk("ldcs_rsp_data", {24'd0, rsp_data}, 32'h30);
    chk("ldcs_rsp_err", {30'd0, rsp_err}, 32'd0);
    rsp_accept();

    // STCS addr 3 data 59, TX FIFO full for 5 cycles after the first push.
    start_test();
    rxq.push_back(8'h55); rxq.push_back(8'hC3); rxq.push_back(8'h59);
    send_cmd(2'd1, 4'h3, 8'h59);
    @(negedge clk);
    tx_fifo_full = 1'b1;
    repeat (5) @(negedge clk);
    chk("stcs_hold_while_full", txq.size(), 32'd1);
    tx_fifo_full = 1'b0;
    wait_rsp(100);
    chk("stcs_tx_count", txq.size(), 32'd3);
    chk("stcs_tx0", {24'd0, txq[0]}, 32'h55);
    chk("stcs_tx1", {24'd0, txq[1]}, 32'hC3);
    chk("stcs_tx2", {24'd0, txq[2]}, 32'h59);
    chk("stcs_push_while_full", wr_viol, 32'd0);
    chk("stcs_rsp_err", {30'd0, rsp_err}, 32'd0);
    chk("stcs_rsp_data", {24'd0, rsp_data}, 32'h00);
    rsp_accept();

    // LDCS with a corrupted second echo.
    start_test();
    rxq.push_back(8'h55); rxq.push_back(8'h81);
    send_cmd(2'd0, 4'h0, 8'h00);
    wait_rsp(100);
    chk("mismatch_rsp_err", {30'd0, rsp_err}, 32'd1);
    chk("mismatch_pops", pops, 32'd2);
    chk("mismatch_rsp_data", {24'd0, rsp_data}, 32'h00);
    rsp_accept();

    // rx_error during echo wins over a pending pop.
    start_test();
    rxq.push_back(8'h55); rxq.push_back(8'h80);
    rx_error = 1'b1;
    send_cmd(2'd0, 4'h0, 8'h00);
    wait_rsp(100);
    chk("rxerr_rsp_err", {30'd0, rsp_err}, 32'd3);
    chk("rxerr_pops", pops, 32'd0);
    rx_error = 1'b0;
    rsp_accept();
    rxq.delete();
    repeat (2) @(negedge clk);

    // LDCS with no read byte: timeout 50 edges after the last echo pop.
    start_test();
    rxq.push_back(8'h55); rxq.push_back(8'h80);
    send_cmd(2'd0, 4'h0, 8'h00);
    wait_rsp(200);
    chk("timeout_rsp_err", {30'd0, rsp_err}, 32'd2);
    chk("timeout_latency", cyc - last_pop_cyc, 32'd50);
    chk("timeout_pops", pops, 32'd2);
    rsp_accept();

    // BREAK with three garbage bytes waiting when the double break completes.
    start_test();
    send_cmd(2'd2, 4'h0, 8'h00);
    repeat (3) @(negedge clk);
    chk("break_waiting_busy", {31'd0, cmd_ready}, 32'd0);
    chk("break_waiting_no_rsp", {31'd0, rsp_valid}, 32'd0);
    rxq.push_back(8'hAA); rxq.push_back(8'h00); rxq.push_back(8'hFF);
    repeat (2) @(negedge clk);
    chk("break_no_early_pop", pops, 32'd0);
    double_break_done = 1'b1;
    rx_error = 1'b1;
    @(negedge clk);
    double_break_done = 1'b0;
    wait_rsp(100);
    rx_error = 1'b0;
    chk("break_start_pulses", starts, 32'd1);
    chk("break_pops", pops, 32'd3);
    chk("break_rsp_err", {30'd0, rsp_err}, 32'd0);
    chk("break_rsp_data", {24'd0, rsp_data}, 32'h00);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("break_rsp_held", {31'd0, rsp_valid}, 32'd1);
    end
    rsp_accept();

    // Reserved op: error response on the cycle after acceptance, no FIFO traffic.
    start_test();
    send_cmd(2'd3, 4'h7, 8'hA5);
    chk("rsvd_rsp_valid", {31'd0, rsp_valid}, 32'd1);
    chk("rsvd_rsp_err", {30'd0, rsp_err}, 32'd3);
    chk("rsvd_tx_count", txq.size(), 32'd0);
    chk("rsvd_pops", pops, 32'd0);
    rsp_accept();

    // Reset while an STCS is waiting for its second echo, then a clean LDCS.
    start_test();
    rxq.push_back(8'h55);
    send_cmd(2'd1, 4'h5, 8'h12);
    repeat (8) @(negedge clk);
    chk("midrst_busy", {31'd0, cmd_ready}, 32'd0);
    chk("midrst_pops_before", pops, 32'd1);
    rst = 1'b1;
    @(negedge clk);
    chk_quiet("midrst");
    rst = 1'b0;
    start_test();
    rxq.push_back(8'h55); rxq.push_back(8'h82); rxq.push_back(8'hA7);
    send_cmd(2'd0, 4'h2, 8'h00);
    wait_rsp(100);
    chk("postrst_tx1", {24'd0, txq[1]}, 32'h82);
    chk("postrst_rsp_data", {24'd0, rsp_data}, 32'hA7);
    chk("postrst_rsp_err", {30'd0, rsp_err}, 32'd0);
    rsp_accept();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
